// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: accepts bitstream words on a valid/ready stream and
// shifts them MSB-first onto the ccff chain until exactly CHAIN_LEN bits are sent.
module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int TIMEOUT   = 1024
) (
    input  logic                               prog_clk,
    input  logic                               prog_reset,
    input  logic                               cfg_start,
    input  logic                               cfg_abort,
    input  logic [WORD_W-1:0]                  s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic                               ccff_head,
    output logic                               cfg_shift_en,
    output logic                               fabric_cfg_mode,
    output logic                               cfg_busy,
    output logic                               cfg_done,
    output logic                               cfg_error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]     bits_left
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int BC_W = $clog2(WORD_W);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [BL_W-1:0] BL_INIT = BL_W'(CHAIN_LEN);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            bits_left_q <= BL_INIT;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            bits_left_q <= bits_left_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    // Abort takes priority over start and handshake; datapath freezes on abort.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        bits_left_d = bits_left_q;
        idle_cnt_d  = idle_cnt_q;
        if (cfg_abort && state_q != ST_IDLE) begin
            state_d = ST_ERR;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (cfg_start) begin
                        state_d     = ST_FETCH;
                        sreg_d      = '0;
                        bit_cnt_d   = '0;
                        bits_left_d = BL_INIT;
                        idle_cnt_d  = '0;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        sreg_d     = s_data;
                        bit_cnt_d  = '0;
                        idle_cnt_d = '0;
                        state_d    = ST_SHIFT;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TO_ONE;
                        if (idle_cnt_d == TO_MAX) state_d = ST_ERR;
                    end
                end
                ST_SHIFT: begin
                    sreg_d      = {sreg_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + BC_ONE;
                    bits_left_d = bits_left_q - BL_ONE;
                    // Chain completion wins over word exhaustion; leftover bits are padding.
                    if (bits_left_q == BL_ONE) state_d = ST_DONE;
                    else if (bit_cnt_q == BC_LAST) state_d = ST_FETCH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready         = (state_q == ST_FETCH);
        cfg_shift_en    = (state_q == ST_SHIFT);
        ccff_head       = (state_q == ST_SHIFT) && sreg_q[WORD_W-1];
        fabric_cfg_mode = (state_q != ST_DONE);
        cfg_busy        = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
        cfg_done        = (state_q == ST_DONE);
        cfg_error       = (state_q == ST_ERR);
        bits_left       = bits_left_q;
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: queue-based reference model compared
// every cycle, plus directed literal checks for the documented scenarios.
module tb_cfg_chain_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;
    localparam int TIMEOUT   = 4;
    localparam int BL_W      = $clog2(CHAIN_LEN + 1);

    localparam int MD_IDLE  = 0;
    localparam int MD_FETCH = 1;
    localparam int MD_SHIFT = 2;
    localparam int MD_DONE  = 3;
    localparam int MD_ERR   = 4;

    logic              prog_clk = 1'b0;
    logic              prog_reset, cfg_start, cfg_abort, s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready, ccff_head, cfg_shift_en, fabric_cfg_mode;
    logic              cfg_busy, cfg_done, cfg_error;
    logic [BL_W-1:0]   bits_left;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // stimulus source and capture
    logic [WORD_W-1:0] words[$];
    bit                cap[$];
    int                widx = 0;
    bit                hs_pend = 1'b0;
    int                zrun = 0;
    int                last_cycles = 0;
    logic [31:0]       last_cap = '0;

    // reference model
    int m_mode = MD_IDLE;
    int m_left = CHAIN_LEN;
    int m_idle = 0;
    bit m_bits[$];

    always #5 prog_clk = ~prog_clk;

    cfg_chain_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .prog_clk       (prog_clk),
        .prog_reset     (prog_reset),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .ccff_head      (ccff_head),
        .cfg_shift_en   (cfg_shift_en),
        .fabric_cfg_mode(fabric_cfg_mode),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_error      (cfg_error),
        .bits_left      (bits_left)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: bits of accepted words queue up MSB-first and drain one per shift cycle.
    always @(posedge prog_clk) begin
        if (prog_reset) begin
            m_mode = MD_IDLE;
            m_left = CHAIN_LEN;
            m_idle = 0;
            m_bits.delete();
        end else if (cfg_abort && m_mode != MD_IDLE) begin
            m_mode = MD_ERR;
        end else if (m_mode == MD_IDLE || m_mode == MD_DONE || m_mode == MD_ERR) begin
            if (cfg_start) begin
                m_mode = MD_FETCH;
                m_left = CHAIN_LEN;
                m_idle = 0;
                m_bits.delete();
            end
        end else if (m_mode == MD_FETCH) begin
            if (s_valid) begin
                for (int i = WORD_W - 1; i >= 0; i--) m_bits.push_back(s_data[i]);
                m_idle = 0;
                m_mode = MD_SHIFT;
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) m_mode = MD_ERR;
            end
        end else begin
            void'(m_bits.pop_front());
            m_left--;
            if (m_left == 0) m_mode = MD_DONE;
            else if (m_bits.size() == 0) m_mode = MD_FETCH;
        end
    end

    always @(negedge prog_clk) begin
        if (chk_en) begin
            chk("s_ready",         s_ready,         32'(m_mode == MD_FETCH));
            chk("cfg_shift_en",    cfg_shift_en,    32'(m_mode == MD_SHIFT));
            chk("ccff_head",       ccff_head,
                32'((m_mode == MD_SHIFT && m_bits.size() > 0) ? m_bits[0] : 1'b0));
            chk("fabric_cfg_mode", fabric_cfg_mode, 32'(m_mode != MD_DONE));
            chk("cfg_busy",        cfg_busy,        32'(m_mode == MD_FETCH || m_mode == MD_SHIFT));
            chk("cfg_done",        cfg_done,        32'(m_mode == MD_DONE));
            chk("cfg_error",       cfg_error,       32'(m_mode == MD_ERR));
            chk("bits_left",       bits_left,       32'(m_left));
            if (cfg_shift_en) cap.push_back(ccff_head);
        end
    end

    // Drive one cycle of inputs, then wait for the following falling edge.
    task automatic tick(input logic rst, input logic st, input logic ab, input int vpct);
        logic v;
        if (hs_pend) widx++;
        while (widx >= words.size()) words.push_back(WORD_W'($urandom));
        prog_reset = rst;
        cfg_start  = st;
        cfg_abort  = ab;
        v = ($urandom_range(99) < vpct);
        if (vpct > 0 && vpct < 100 && zrun >= 2) v = 1'b1;
        zrun    = v ? 0 : zrun + 1;
        s_valid = v;
        s_data  = words[widx];
        hs_pend = v && s_ready;
        @(negedge prog_clk);
    endtask

    task automatic run_load(input int vpct, input string tag);
        int n;
        logic [31:0] capv, expv;
        cap.delete();
        widx    = 0;
        hs_pend = 1'b0;
        tick(1'b0, 1'b1, 1'b0, vpct);
        chk({tag, "_start_done"}, cfg_done, 0);
        chk({tag, "_start_mode"}, fabric_cfg_mode, 1);
        n = 0;
        while (!cfg_done && !cfg_error && n < 2000) begin
            tick(1'b0, 1'b0, 1'b0, vpct);
            n++;
        end
        chk({tag, "_done"}, cfg_done, 1);
        chk({tag, "_pulses"}, cap.size(), CHAIN_LEN);
        capv = '0;
        expv = '0;
        foreach (cap[i]) if (i < CHAIN_LEN) capv[CHAIN_LEN-1-i] = cap[i];
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (i / WORD_W < words.size())
                expv[CHAIN_LEN-1-i] = words[i/WORD_W][WORD_W-1-(i%WORD_W)];
        end
        chk({tag, "_stream"}, capv, expv);
        last_cycles = n;
        last_cap    = capv;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] saved;
        prog_reset = 1'b1;
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        @(negedge prog_clk);
        tick(1'b1, 1'b0, 1'b0, 0);
        chk_en = 1'b1;
        chk("rst_bits_left", bits_left, CHAIN_LEN);
        chk("rst_mode", fabric_cfg_mode, 1);
        chk("rst_ready", s_ready, 0);

        // abort in IDLE is ignored
        tick(1'b0, 1'b0, 1'b1, 0);
        chk("idle_abort_err", cfg_error, 0);

        // clean load with documented words
        words.delete();
        words.push_back(8'hA5);
        words.push_back(8'h3C);
        words.push_back(8'hF0);
        run_load(100, "clean");
        chk("clean_cycles", last_cycles, 23);
        chk("clean_bits", last_cap, 32'h000A53CF);
        chk("clean_left0", bits_left, 0);
        tick(1'b0, 1'b0, 1'b0, 100);
        chk("done_no_ready", s_ready, 0);

        // stalled source
        tick(1'b0, 1'b1, 1'b0, 0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 0);
        chk("stall3_err", cfg_error, 0);
        tick(1'b0, 1'b0, 1'b0, 0);
        chk("stall4_err", cfg_error, 1);
        chk("stall4_shift", cfg_shift_en, 0);
        chk("stall4_mode", fabric_cfg_mode, 1);
        tick(1'b0, 1'b1, 1'b0, 0);
        chk("restart_err", cfg_error, 0);
        chk("restart_ready", s_ready, 1);

        // abort after 5 bits shifted
        words.delete();
        widx = 0;
        hs_pend = 1'b0;
        n = 0;
        while (!(cfg_shift_en && bits_left == BL_W'(CHAIN_LEN - 5)) && n < 100) begin
            tick(1'b0, 1'b0, 1'b0, 100);
            n++;
        end
        chk("abort_reach", bits_left, CHAIN_LEN - 5);
        tick(1'b0, 1'b0, 1'b1, 100);
        chk("abort_err", cfg_error, 1);
        chk("abort_shift", cfg_shift_en, 0);
        chk("abort_left", bits_left, CHAIN_LEN - 5);
        tick(1'b0, 1'b1, 1'b1, 100);
        chk("abort_start_err", cfg_error, 1);

        // reset mid-word, then reload from bit 0
        words.delete();
        widx = 0;
        hs_pend = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 100);
        n = 0;
        while (bits_left != BL_W'(CHAIN_LEN - 3) && n < 100) begin
            tick(1'b0, 1'b0, 1'b0, 100);
            n++;
        end
        tick(1'b1, 1'b0, 1'b0, 100);
        chk("mrst_left", bits_left, CHAIN_LEN);
        chk("mrst_busy", cfg_busy, 0);
        chk("mrst_head", ccff_head, 0);
        tick(1'b0, 1'b0, 1'b0, 0);
        run_load(100, "after_rst");

        // abort+start together from DONE
        tick(1'b0, 1'b1, 1'b1, 100);
        chk("done_abort_start", cfg_error, 1);

        // randomized backpressure loads, each followed by an identical restart
        for (int k = 0; k < 12; k++) begin
            words.delete();
            run_load($urandom_range(40, 90), "rand");
            saved = last_cap;
            run_load($urandom_range(40, 90), "again");
            chk("again_same", last_cap, saved);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
